// File: rtl/password_programmer.sv
// Password programmer: a three-step change session (old / new / confirm)
// that updates the stored compare value used by the checker side.
// Optional consecutive-failure lockout is compiled in with
// `define PWD_PROGRAMMER_LOCKOUT_EN; without it, LOCK and its counter are absent.
module password_programmer #(
  parameter logic [2:0] RESET_PWD   = 3'b101,
  parameter int         MAX_FAIL    = 3,
  parameter int         LOCK_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] pwd_in,
  input  logic       set_req,
  input  logic       enter,
  output logic [2:0] pwd_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       locked
);

  localparam int FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE, OLD, NEW, CONF
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
    , LOCK
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    new_pwd, new_nxt, pwd_nxt;
  logic [FW-1:0] fail_cnt, fail_nxt;
  logic          set_q, enter_q;
  logic          done_nxt, error_nxt;
  logic          set_edge, enter_edge;

`ifdef PWD_PROGRAMMER_LOCKOUT_EN
  localparam int LW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_PRE  = FW'(MAX_FAIL - 1);
  logic [LW-1:0] lock_cnt, lock_nxt;
`endif

  assign set_edge   = set_req & ~set_q;
  assign enter_edge = enter & ~enter_q;
  assign busy       = (state != IDLE);
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
  assign locked     = (state == LOCK);
`else
  assign locked     = 1'b0;
`endif

  // State, stored/pending passwords, fail counter, edge history, flag pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pwd_out  <= RESET_PWD;
      new_pwd  <= '0;
      fail_cnt <= '0;
      set_q    <= 1'b0;
      enter_q  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pwd_out  <= pwd_nxt;
      new_pwd  <= new_nxt;
      fail_cnt <= fail_nxt;
      set_q    <= set_req;
      enter_q  <= enter;
      done     <= done_nxt;
      error    <= error_nxt;
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
      lock_cnt <= lock_nxt;
`endif
    end
  end

  // Session decisions; every step acts on the edge that registers enter high
  always_comb begin
    state_nxt = state;
    pwd_nxt   = pwd_out;
    new_nxt   = new_pwd;
    fail_nxt  = fail_cnt;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
    lock_nxt  = lock_cnt;
`endif
    case (state)
      // set_req is only looked at here, so it cannot restart a session
      IDLE: if (set_edge) state_nxt = OLD;
      OLD: if (enter_edge) begin
        if (pwd_in == pwd_out) begin
          fail_nxt  = '0;
          state_nxt = NEW;
        end else begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
          if (fail_cnt != FAIL_MAX) fail_nxt = fail_cnt + 1'b1;
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
          if (fail_cnt == FAIL_PRE) begin
            state_nxt = LOCK;
            lock_nxt  = '0;
          end
`endif
        end
      end
      NEW: if (enter_edge) begin
        new_nxt   = pwd_in;
        state_nxt = CONF;
      end
      CONF: if (enter_edge) begin
        if (pwd_in == new_pwd) begin
          pwd_nxt  = new_pwd;
          done_nxt = 1'b1;
        end else begin
          error_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
      // Count 0..LOCK_CYCLES-1 so LOCK is occupied exactly LOCK_CYCLES cycles
      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt = IDLE;
          fail_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_password_programmer.sv
// Directed bench for password_programmer: reset, change, mismatch, held
// enter, ignored set_req while busy, reset mid-session, repeated wrong
// old password (with lockout when PWD_PROGRAMMER_LOCKOUT_EN is defined).
module tb_password_programmer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_req = 1'b0;
  logic       enter = 1'b0;
  logic [2:0] pwd_in = 3'b000;
  logic [2:0] pwd_out;
  logic       busy, done, error, locked;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  password_programmer #(
    .RESET_PWD  (3'b101),
    .MAX_FAIL   (3),
    .LOCK_CYCLES(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwd_in (pwd_in),
    .set_req(set_req),
    .enter  (enter),
    .pwd_out(pwd_out),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .locked (locked)
  );

  // Pulse counters sampled on the opposite edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_set();
    set_req = 1'b1;
    cyc();
    set_req = 1'b0;
    cyc();
  endtask

  // One-cycle enter pulse; returns the flags seen right after the decision edge
  task automatic press(input logic [2:0] v, output logic d, output logic e);
    pwd_in = v;
    enter  = 1'b1;
    cyc();
    d = done;
    e = error;
    enter = 1'b0;
    cyc();
  endtask

  initial begin
    logic d, e;
    int   d0, e0, n;

    // Reset
    cyc(); cyc();
    chk("rst_pwd", pwd_out, 3'b101);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_locked", locked, 0);
    rst_n = 1'b1;
    cyc();

    // Successful change 101 -> 010
    d0 = done_cnt; e0 = err_cnt;
    pulse_set();
    chk("ok_busy_old", busy, 1);
    press(3'b101, d, e);
    chk("ok_old_err", e, 0);
    press(3'b010, d, e);
    chk("ok_new_done", d, 0);
    press(3'b010, d, e);
    chk("ok_conf_done", d, 1);
    chk("ok_done_drop", done, 0);
    chk("ok_pwd", pwd_out, 3'b010);
    chk("ok_idle", busy, 0);
    chk("ok_done_cnt", done_cnt - d0, 1);
    chk("ok_err_cnt", err_cnt - e0, 0);

    // Reset restores default password
    rst_n = 1'b0; #1;
    chk("rst2_pwd", pwd_out, 3'b101);
    cyc(); rst_n = 1'b1; cyc();

    // Confirm mismatch
    d0 = done_cnt; e0 = err_cnt;
    pulse_set();
    press(3'b101, d, e);
    press(3'b010, d, e);
    press(3'b011, d, e);
    chk("mm_err", e, 1);
    chk("mm_err_drop", error, 0);
    chk("mm_pwd", pwd_out, 3'b101);
    chk("mm_idle", busy, 0);
    chk("mm_err_cnt", err_cnt - e0, 1);
    chk("mm_done_cnt", done_cnt - d0, 0);

    // enter ignored in IDLE
    press(3'b101, d, e);
    chk("idle_enter", busy, 0);

    // enter held 10 cycles in OLD consumes one step; set_req in NEW ignored
    d0 = done_cnt; e0 = err_cnt;
    pulse_set();
    pwd_in = 3'b101;
    enter  = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    enter = 1'b0;
    cyc();
    chk("hold_busy", busy, 1);
    chk("hold_err", err_cnt - e0, 0);
    pulse_set();
    chk("new_set_busy", busy, 1);
    press(3'b011, d, e);
    chk("hold_new_err", e, 0);
    press(3'b011, d, e);
    chk("hold_conf_done", d, 1);
    chk("hold_pwd", pwd_out, 3'b011);
    chk("hold_err_total", err_cnt - e0, 0);

    // Reset asserted during CONF
    d0 = done_cnt;
    pulse_set();
    press(3'b011, d, e);
    press(3'b110, d, e);
    chk("conf_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("rstc_pwd", pwd_out, 3'b101);
    chk("rstc_busy", busy, 0);
    pwd_in = 3'b110; enter = 1'b1;
    cyc(); cyc();
    enter = 1'b0;
    rst_n = 1'b1;
    cyc(); cyc();
    chk("rstc_done", done_cnt - d0, 0);
    chk("rstc_pwd2", pwd_out, 3'b101);
    chk("rstc_idle", busy, 0);

    // Repeated wrong old password
    e0 = err_cnt; d0 = done_cnt;
    pulse_set();
    press(3'b000, d, e);
    chk("wr1_err", e, 1);
    chk("wr1_idle", busy, 0);
    pulse_set();
    press(3'b000, d, e);
    chk("wr2_err", e, 1);
    chk("wr2_locked", locked, 0);
    pulse_set();
    pwd_in = 3'b000;
    enter  = 1'b1;
    cyc();
    chk("wr3_err", error, 1);
`ifdef PWD_PROGRAMMER_LOCKOUT_EN
    chk("wr3_locked", locked, 1);
    chk("wr3_busy", busy, 1);
    n = 1;
    // Toggle enter and set_req during lock; all edges must be ignored
    for (int i = 0; i < 20; i++) begin
      enter   = ~enter;
      set_req = ~set_req;
      cyc();
      if (locked) n++;
      else break;
    end
    chk("lock_len", n, 8);
    chk("lock_exit_busy", busy, 0);
    enter = 1'b0; set_req = 1'b0;
    cyc();
    chk("lock_exit_idle", busy, 0);
`else
    chk("wr3_locked", locked, 0);
    chk("wr3_idle", busy, 0);
    enter = 1'b0;
    cyc();
`endif
    chk("wr_err_cnt", err_cnt - e0, 3);
    chk("wr_done_cnt", done_cnt - d0, 0);

    // Correct session after the failures
    pulse_set();
    press(3'b101, d, e);
    chk("after_old_err", e, 0);
    press(3'b100, d, e);
    press(3'b100, d, e);
    chk("after_done", d, 1);
    chk("after_pwd", pwd_out, 3'b100);

    chk("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
